// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline control-register chain.
// Default NOP word and the width of the control-unit output bundle.
package pipe_pkg;

  // Wide enough for any stage width; modules truncate to their own WIDTH.
  localparam logic [63:0] NOP_WORD_DEFAULT = '0;

  // Shift 1, ALU 4, size 2, enable 1, rw 1, load 1, S 1, RF 1, B 1, BL 1.
  localparam int unsigned CONTROL_W = 1 + 4 + 2 + 1 + 1 + 1 + 1 + 1 + 1 + 1;

  typedef struct packed {
    logic       shift;
    logic [3:0] alu;
    logic [1:0] size;
    logic       enable;
    logic       rw;
    logic       load;
    logic       s;
    logic       rf;
    logic       b;
    logic       bl;
  } ctrl_t;

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake and status bundle between the NOP mux, the stage chain and the hazard unit.
interface pipe_stage_chain_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned OCC_W  = $clog2(STAGES + 1)
);

  logic [WIDTH-1:0]        in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [STAGES-1:0]       stall;
  logic [STAGES-1:0]       flush;
  logic [STAGES*WIDTH-1:0] stage_data;
  logic [STAGES-1:0]       stage_valid;
  logic [CNT_W-1:0]        retire_cnt;
  logic [OCC_W-1:0]        occupancy;

  modport master (
    output in_data, in_valid, stall, flush,
    input  in_ready, stage_data, stage_valid, retire_cnt, occupancy
  );

  modport slave (
    input  in_data, in_valid, stall, flush,
    output in_ready, stage_data, stage_valid, retire_cnt, occupancy
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline control register: word plus valid bit with flush > hold > bubble > advance.
// Stage 0 is wired with up_hold tied low and the chain input as its upstream word.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] NOP_WORD = '0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             hold,
  input  logic             flush,
  input  logic             up_hold,
  input  logic [WIDTH-1:0] up_word,
  input  logic             up_valid,
  output logic [WIDTH-1:0] word,
  output logic             valid
);

  logic [WIDTH-1:0] word_d, word_q;
  logic             valid_d, valid_q;

  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    if (flush) begin
      word_d  = NOP_WORD;
      valid_d = 1'b0;
    end else if (hold) begin
      word_d  = word_q;
      valid_d = valid_q;
    end else if (up_hold) begin
      // Upstream is frozen, so this stage gets a bubble rather than a duplicate.
      word_d  = NOP_WORD;
      valid_d = 1'b0;
    end else begin
      word_d  = up_word;
      valid_d = up_valid;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      word_q  <= NOP_WORD;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word  = word_q;
  assign valid = valid_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Configurable-depth chain of pipeline control registers with stall propagation,
// per-stage flush, saturating retire counter and occupancy popcount.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      STAGES   = 4,
  parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(NOP_WORD_DEFAULT),
  parameter int unsigned      CNT_W    = 16
) (
  input logic                 CLK,
  input logic                 CLR,
  pipe_stage_chain_if.slave   bus
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] up_hold;
  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] valid;
  logic [WIDTH-1:0]  up_word [STAGES];
  logic [WIDTH-1:0]  word    [STAGES];

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             retire;
  logic [OCC_W-1:0] occ;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // A stall anywhere downstream freezes this stage too.
    assign hold[k] = |bus.stall[STAGES-1:k];

    if (k == 0) begin : g_first
      assign up_hold[k]  = 1'b0;
      assign up_word[k]  = bus.in_data;
      assign up_valid[k] = bus.in_valid;
    end else begin : g_rest
      assign up_hold[k]  = hold[k-1];
      assign up_word[k]  = word[k-1];
      assign up_valid[k] = valid[k-1];
    end

    pipe_stage_reg #(
      .WIDTH    (WIDTH),
      .NOP_WORD (NOP_WORD)
    ) u_stage (
      .CLK      (CLK),
      .CLR      (CLR),
      .hold     (hold[k]),
      .flush    (bus.flush[k]),
      .up_hold  (up_hold[k]),
      .up_word  (up_word[k]),
      .up_valid (up_valid[k]),
      .word     (word[k]),
      .valid    (valid[k])
    );

    assign bus.stage_data[k*WIDTH +: WIDTH] = word[k];
  end

  assign bus.stage_valid = valid;
  assign bus.in_ready    = ~hold[0];

  assign retire = valid[STAGES-1] & ~hold[STAGES-1] & ~bus.flush[STAGES-1];

  always_comb begin
    cnt_d = cnt_q;
    if (retire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.retire_cnt = cnt_q;

  always_comb begin
    occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + OCC_W'(valid[k]);
    end
  end

  assign bus.occupancy = occ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: reset, streaming, stall, flush, flush+stall,
// mid-stream reset and retire-counter saturation on a narrow-counter instance.
module tb_pipe_stage_chain;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  always #5 CLK = ~CLK;

  pipe_stage_chain_if #(.WIDTH(16), .STAGES(4), .CNT_W(16)) bus ();
  pipe_stage_chain_if #(.WIDTH(16), .STAGES(4), .CNT_W(3))  bus_s ();

  pipe_stage_chain #(
    .WIDTH(16), .STAGES(4), .NOP_WORD(16'h0000), .CNT_W(16)
  ) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  pipe_stage_chain #(
    .WIDTH(16), .STAGES(4), .NOP_WORD(16'h0000), .CNT_W(3)
  ) dut_s (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.stall      = '0;
    bus.flush      = '0;
    bus_s.in_data  = '0;
    bus_s.in_valid = 1'b0;
    bus_s.stall    = '0;
    bus_s.flush    = '0;

    // Reset state
    tick();
    tick();
    chk("rst_valid", 64'(bus.stage_valid), 64'h0);
    chk("rst_data", bus.stage_data, 64'h0);
    chk("rst_cnt", 64'(bus.retire_cnt), 64'h0);
    chk("rst_occ", 64'(bus.occupancy), 64'h0);
    chk("rst_ready", 64'(bus.in_ready), 64'h1);
    bus.stall = 4'b0010;
    #1;
    chk("rst_ready_stall", 64'(bus.in_ready), 64'h0);
    bus.stall = '0;
    CLR = 1'b1;

    // Streaming 0x0A01..0x0A06
    for (int i = 0; i < 6; i++) begin
      bus.in_data  = 16'h0A01 + 16'(i);
      bus.in_valid = 1'b1;
      tick();
      if (i == 3) begin
        chk("stream_s3_first", 64'(bus.stage_data[63:48]), 64'h0A01);
        chk("stream_full", bus.stage_data, 64'h0A01_0A02_0A03_0A04);
        chk("stream_occ_peak", 64'(bus.occupancy), 64'h4);
      end
    end
    chk("stream_cnt_mid", 64'(bus.retire_cnt), 64'h2);
    chk("stream_occ_hold", 64'(bus.occupancy), 64'h4);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("stream_cnt_end", 64'(bus.retire_cnt), 64'h6);
    chk("stream_occ_end", 64'(bus.occupancy), 64'h0);

    // Stall at stage 1 for two cycles
    for (int i = 0; i < 4; i++) begin
      bus.in_data  = 16'h0B01 + 16'(i);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_data = 16'h0B05;
    bus.stall   = 4'b0010;
    #1;
    chk("stall_ready0", 64'(bus.in_ready), 64'h0);
    tick();
    chk("stall1_data", bus.stage_data, 64'h0B02_0000_0B03_0B04);
    chk("stall1_valid", 64'(bus.stage_valid), 64'hB);
    chk("stall1_cnt", 64'(bus.retire_cnt), 64'd7);
    chk("stall1_ready", 64'(bus.in_ready), 64'h0);
    tick();
    chk("stall2_data", bus.stage_data, 64'h0000_0000_0B03_0B04);
    chk("stall2_valid", 64'(bus.stage_valid), 64'h3);
    chk("stall2_cnt", 64'(bus.retire_cnt), 64'd8);
    bus.stall = '0;
    #1;
    chk("stall_ready_back", 64'(bus.in_ready), 64'h1);
    tick();
    chk("unstall_data", bus.stage_data, 64'h0000_0B03_0B04_0B05);
    chk("unstall_valid", 64'(bus.stage_valid), 64'h7);
    chk("unstall_cnt", 64'(bus.retire_cnt), 64'd8);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tick();
    chk("drain_b03", 64'(bus.stage_data[63:48]), 64'h0B03);
    tick();
    chk("drain_b04", 64'(bus.stage_data[63:48]), 64'h0B04);
    chk("drain_b04_cnt", 64'(bus.retire_cnt), 64'd9);
    tick();
    chk("drain_b05", 64'(bus.stage_data[63:48]), 64'h0B05);
    tick();
    chk("stall_cnt_end", 64'(bus.retire_cnt), 64'd11);
    chk("stall_occ_end", 64'(bus.occupancy), 64'h0);

    // Flush stages 0 and 1 with the pipe full; input offered that cycle is dropped
    for (int i = 0; i < 4; i++) begin
      bus.in_data  = 16'h0C01 + 16'(i);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_data = 16'h0C05;
    bus.flush   = 4'b0011;
    #1;
    chk("flush_ready", 64'(bus.in_ready), 64'h1);
    tick();
    chk("flush_data", bus.stage_data, 64'h0C02_0C03_0000_0000);
    chk("flush_valid", 64'(bus.stage_valid), 64'hC);
    chk("flush_cnt", 64'(bus.retire_cnt), 64'd12);
    bus.flush    = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("flush_cnt_end", 64'(bus.retire_cnt), 64'd14);
    chk("flush_occ_end", 64'(bus.occupancy), 64'h0);

    // flush[2] together with stall[2]
    for (int i = 0; i < 4; i++) begin
      bus.in_data  = 16'h0D01 + 16'(i);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_data = 16'h0D05;
    bus.stall   = 4'b0100;
    bus.flush   = 4'b0100;
    #1;
    chk("fs_ready", 64'(bus.in_ready), 64'h0);
    tick();
    chk("fs_data", bus.stage_data, 64'h0000_0000_0D03_0D04);
    chk("fs_valid", 64'(bus.stage_valid), 64'h3);
    chk("fs_cnt", 64'(bus.retire_cnt), 64'd15);
    bus.stall    = '0;
    bus.flush    = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("fs_cnt_end", 64'(bus.retire_cnt), 64'd17);
    chk("fs_occ_end", 64'(bus.occupancy), 64'h0);

    // Reset mid-stream
    for (int i = 0; i < 4; i++) begin
      bus.in_data  = 16'h1111 * 16'(i + 1);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    chk("fill_data", bus.stage_data, 64'h1111_2222_3333_4444);
    #2;
    CLR = 1'b0;
    #1;
    chk("midrst_data", bus.stage_data, 64'h0);
    chk("midrst_valid", 64'(bus.stage_valid), 64'h0);
    chk("midrst_cnt", 64'(bus.retire_cnt), 64'h0);
    chk("midrst_occ", 64'(bus.occupancy), 64'h0);
    bus.stall = 4'b0100;
    #1;
    chk("midrst_ready_stall", 64'(bus.in_ready), 64'h0);
    bus.stall = '0;
    #1;
    chk("midrst_ready", 64'(bus.in_ready), 64'h1);
    CLR = 1'b1;

    // Saturation on the 3-bit counter instance
    for (int i = 0; i < 10; i++) begin
      bus_s.in_data  = 16'h5000 + 16'(i);
      bus_s.in_valid = 1'b1;
      tick();
    end
    bus_s.in_valid = 1'b0;
    bus_s.in_data  = '0;
    chk("sat_cnt6", 64'(bus_s.retire_cnt), 64'd6);
    tick();
    chk("sat_cnt7", 64'(bus_s.retire_cnt), 64'd7);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_cnt_stuck", 64'(bus_s.retire_cnt), 64'd7);
    chk("sat_occ_end", 64'(bus_s.occupancy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised pipeline register chain replacing the fixed IF/ID, ID/EX, EX/MEM and MEM/WB control registers with one block of configurable depth and word width. Each stage holds a control word plus a valid bit, supports per-stage stall (hold) and flush (bubble), propagates stalls upstream, and inserts NOP bubbles below a stalled stage. The chain sits between the control-unit/NOP mux output and the datapath stages, and it reports retire count and occupancy for the hazard unit and the testbench.

## Interface
Parameters:
- WIDTH, 16: control-word width per stage.
- STAGES, 4: number of pipeline registers, 2..8. Stage 0 is the first (IF/ID-equivalent).
- NOP_WORD, all-zero: word loaded on reset, flush and bubble.
- CNT_W, 16: retire counter width.

Ports:
- CLK, in, 1: clock. All state updates on the rising edge.
- CLR, in, 1: asynchronous, active-low reset.
- in_data, in, WIDTH: word offered to stage 0.
- in_valid, in, 1: in_data is a real instruction.
- in_ready, out, 1: stage 0 accepts this cycle.
- stall, in, STAGES: bit k requests stage k to hold.
- flush, in, STAGES: bit k replaces stage k with a bubble.
- stage_data, out, STAGES*WIDTH: stage k word at bits [k*WIDTH +: WIDTH].
- stage_valid, out, STAGES: valid bit per stage.
- retire_cnt, out, CNT_W: number of valid words that have left the last stage. Saturating.
- occupancy, out, ceil(log2(STAGES+1)): popcount of stage_valid. Combinational.

## Operation
- hold[k] = OR of stall[j] for j >= k. A stall at stage k freezes stage k and every upstream stage.
- Per-stage next state, in priority order:
  1. flush[k]: word becomes NOP_WORD and valid becomes 0. This overrides hold.
  2. hold[k]: word and valid keep their current values.
  3. k = 0: load in_data and in_valid.
  4. k > 0 and hold[k-1]: bubble (NOP_WORD, valid 0).
  5. Otherwise: take the word and valid from stage k-1.
- in_ready = ~hold[0]. Stage 0 loads the input when in_ready is 1 and flush[0] is 0. When flush[0] is 1, the input word is dropped even if in_ready is 1.
- Retire: a word retires when stage_valid[STAGES-1] = 1, hold[STAGES-1] = 0 and flush[STAGES-1] = 0. A flushed last-stage word does not retire.
- On each retire, retire_cnt increments by 1. It sticks at 2^CNT_W - 1.
- A stage holding a bubble (valid 0) advances like any word but never counts toward retire_cnt.
- stage_data and stage_valid are driven straight from the registers, with no combinational path from stall or flush.

## Timing
- Reset (CLR low, asynchronous): every stage word = NOP_WORD, stage_valid = 0, retire_cnt = 0, occupancy = 0.
- Only in_ready is combinational from stall. Its value during reset follows stall.
- Release of CLR is synchronised externally; the block has no reset-release requirement.
- Latency: a word accepted at edge t appears in stage k after edge t+k, assuming no holds. It retires on edge t+STAGES.
- Stall for n cycles at stage k:
  - stage k and all upstream stages hold for n edges;
  - stage k+1 receives n bubbles;
  - in_ready is 0 for those n cycles.
- Simultaneous flush[k] and stall[k]: stage k becomes a bubble and upstream stages still hold.
- Simultaneous flush[k] and stall[j], j > k: stage k becomes a bubble and does not move.
- Flush of all stages in one cycle: the chain is empty next cycle and retire_cnt is unchanged.
- Back-to-back accept, 1 word per cycle, is required when there are no holds.

## Structure
- Shared package pipe_pkg holds:
  - the default NOP_WORD constant;
  - the CONTROL_W localparam matching the control-unit output bundle: Shift 1, ALU 4, size 2, enable 1, rw 1, load 1, S 1, RF 1, B 1, BL 1.
- Sub-module pipe_stage_reg implements one stage: word, valid, and the 5-way next-state priority above, taking hold, flush and upstream-hold inputs.
- pipe_stage_chain instantiates STAGES copies of pipe_stage_reg with a generate loop. It also contains the hold prefix-OR, the retire counter and the occupancy popcount.

## Test plan
Defaults throughout: WIDTH = 16, STAGES = 4, NOP_WORD = 0.
- Reset mid-stream: fill the pipe with 0x1111..0x4444, then pulse CLR low between edges → all stage_data = 0 and stage_valid = 0 immediately, retire_cnt = 0.
- Streaming: feed 0x0A01..0x0A06 on consecutive cycles with no stalls → stage 3 shows 0x0A01 after edge 4; retire_cnt = 6 four cycles after the last accept; occupancy peaks at 4.
- Stall at stage 1 for 2 cycles while streaming → stages 0 and 1 frozen; stage 2 shows two bubbles (valid 0); in_ready = 0 for exactly 2 cycles; no word lost or duplicated; retire order is preserved.
- Flush of stage 0 and stage 1 together (branch taken) with pipe full → those stages become NOP; the 2 older words retire; retire_cnt increases by 2, not 4.
- flush[2] and stall[2] in the same cycle → stage 2 becomes a bubble; stages 0 and 1 hold; stage 3 advances normally.
- Saturation: CNT_W = 3, stream 10 valid words → retire_cnt stops at 7.
